// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS register file slice: register-file
// geometry constants and the dump state encoding.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_GPR    = 32;
    localparam int REG_ZERO   = 0;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        DUMP   = 2'd2,
        DONE   = 2'd3
    } regfile_state_t;

endpackage

// File: rtl/regfile_dump_fsm.sv
// Run/halt/dump controller for the register file. Tracks the architectural
// state, walks a pointer over every register during a dump and drives the
// valid/done handshake. Outputs are registered alongside the state.
module regfile_dump_fsm
    import mips_pkg::*;
#(
    parameter int NUM_REGS   = NUM_GPR,
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  halt,
    input  logic                  dump_start,
    input  logic                  dump_ready,
    output regfile_state_t        state,
    output logic                  halted,
    output logic                  dump_valid,
    output logic [ADDR_WIDTH-1:0] dump_addr,
    output logic                  dump_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

    regfile_state_t        state_reg;
    logic [ADDR_WIDTH-1:0] ptr_reg;
    logic                  halted_reg;
    logic                  valid_reg;
    logic                  done_reg;

    // State, dump pointer and handshake outputs advance together so the
    // outputs always reflect the state being entered.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg  <= RUN;
            ptr_reg    <= '0;
            halted_reg <= 1'b0;
            valid_reg  <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (halt) begin
                        state_reg  <= HALTED;
                        halted_reg <= 1'b1;
                    end
                end
                HALTED: begin
                    if (dump_start) begin
                        state_reg <= DUMP;
                        ptr_reg   <= '0;
                        valid_reg <= 1'b1;
                    end
                end
                DUMP: begin
                    // Pointer holds while the debug unit stalls; the last
                    // accepted word ends the dump without wrapping.
                    if (dump_ready) begin
                        if (ptr_reg == LAST_ADDR) begin
                            state_reg <= DONE;
                            valid_reg <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            ptr_reg <= ptr_reg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg <= HALTED;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg  <= RUN;
                    halted_reg <= 1'b0;
                    valid_reg  <= 1'b0;
                    done_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign state      = state_reg;
    assign halted     = halted_reg;
    assign dump_valid = valid_reg;
    assign dump_addr  = ptr_reg;
    assign dump_done  = done_reg;

endmodule

// File: rtl/mips_register_file.sv
// 32 x 32-bit MIPS general-purpose register file at the end of writeback.
// Two combinational read ports serve ID; after halt the contents are frozen
// and can be streamed out over a valid/ready dump port.
// Build option: define REGFILE_WRITE_BYPASS_EN to make the read ports return
// the in-flight write data when they address the register being written.
module mips_register_file
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_W,
    parameter int NUM_REGS   = NUM_GPR,
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [ADDR_WIDTH-1:0] i_rs_addr,
    input  logic [ADDR_WIDTH-1:0] i_rt_addr,
    output logic [DATA_WIDTH-1:0] o_rs_data,
    output logic [DATA_WIDTH-1:0] o_rt_data,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_halt,
    output logic                  o_halted,
    input  logic                  i_dump_start,
    input  logic                  i_dump_ready,
    output logic                  o_dump_valid,
    output logic [ADDR_WIDTH-1:0] o_dump_addr,
    output logic [DATA_WIDTH-1:0] o_dump_data,
    output logic                  o_dump_done
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

    regfile_state_t        state;
    logic                  write_commit;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Only a running core may update state; r0 never takes a write.
    assign write_commit = i_wr_en && (i_wr_addr != ZERO_ADDR) && (state == RUN);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == REG_ZERO) begin : g_zero
                assign regs[gi] = '0;
            end else begin : g_gpr
                logic [DATA_WIDTH-1:0] q_reg;

                // One storage word per register, cleared on reset.
                always_ff @(posedge i_clk) begin
                    if (i_reset) begin
                        q_reg <= '0;
                    end else if (write_commit && (i_wr_addr == ADDR_WIDTH'(gi))) begin
                        q_reg <= i_wr_data;
                    end
                end

                assign regs[gi] = q_reg;
            end
        end
    endgenerate

`ifdef REGFILE_WRITE_BYPASS_EN
    // Write-through: a read of the register being committed this cycle sees
    // the new value, closing the WB->ID hazard inside the register file.
    assign o_rs_data = (write_commit && (i_rs_addr == i_wr_addr)) ? i_wr_data : regs[i_rs_addr];
    assign o_rt_data = (write_commit && (i_rt_addr == i_wr_addr)) ? i_wr_data : regs[i_rt_addr];
`else
    // Reads return the stored (pre-edge) value; hazards are handled upstream.
    assign o_rs_data = regs[i_rs_addr];
    assign o_rt_data = regs[i_rt_addr];
`endif

    regfile_dump_fsm #(
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_dump_fsm (
        .clk        (i_clk),
        .srst       (i_reset),
        .halt       (i_halt),
        .dump_start (i_dump_start),
        .dump_ready (i_dump_ready),
        .state      (state),
        .halted     (o_halted),
        .dump_valid (o_dump_valid),
        .dump_addr  (o_dump_addr),
        .dump_done  (o_dump_done)
    );

    // Third read mux feeding the dump port; the array is frozen while halted
    // so the word stays stable for as long as the debug unit stalls.
    assign o_dump_data = regs[o_dump_addr];

endmodule

// File: tb/tb_mips_register_file.sv
// Scoreboard bench for mips_register_file. Stimulus pushes expected values
// into queues; a negedge monitor pops and compares them against the DUT.
module tb_mips_register_file;

    localparam int K_RS      = 0;
    localparam int K_RT      = 1;
    localparam int K_HALTED  = 2;
    localparam int K_VALID   = 3;
    localparam int K_DONE    = 4;
    localparam int K_DADDR   = 5;
    localparam int K_DONECNT = 6;
    localparam int K_DUMPQ   = 7;
    localparam int K_TIMEOUT = 8;

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam logic [31:0] BYP_R7 = 32'hA5A5_A5A5;
`else
    localparam logic [31:0] BYP_R7 = 32'h0000_0000;
`endif

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } chk_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } dw_t;

    logic        clk;
    logic        i_reset;
    logic [4:0]  i_rs_addr;
    logic [4:0]  i_rt_addr;
    logic [31:0] o_rs_data;
    logic [31:0] o_rt_data;
    logic        i_wr_en;
    logic [4:0]  i_wr_addr;
    logic [31:0] i_wr_data;
    logic        i_halt;
    logic        o_halted;
    logic        i_dump_start;
    logic        i_dump_ready;
    logic        o_dump_valid;
    logic [4:0]  o_dump_addr;
    logic [31:0] o_dump_data;
    logic        o_dump_done;

    chk_t check_q[$];
    dw_t  dump_q[$];

    int errors = 0;
    int checks = 0;
    int done_seen = 0;

    chk_t        mon_c;
    dw_t         mon_w;
    logic [31:0] mon_act;
    logic        stab_armed = 1'b0;
    logic [4:0]  held_addr;
    logic [31:0] held_data;

    mips_register_file dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_rs_addr    (i_rs_addr),
        .i_rt_addr    (i_rt_addr),
        .o_rs_data    (o_rs_data),
        .o_rt_data    (o_rt_data),
        .i_wr_en      (i_wr_en),
        .i_wr_addr    (i_wr_addr),
        .i_wr_data    (i_wr_data),
        .i_halt       (i_halt),
        .o_halted     (o_halted),
        .i_dump_start (i_dump_start),
        .i_dump_ready (i_dump_ready),
        .o_dump_valid (o_dump_valid),
        .o_dump_addr  (o_dump_addr),
        .o_dump_data  (o_dump_data),
        .o_dump_done  (o_dump_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: dump handshake scoreboard, stability of stalled words, and
    // draining of all pending expectations, all sampled mid-cycle.
    always @(negedge clk) begin
        if (o_dump_valid && stab_armed) begin
            checks++;
            if (o_dump_addr !== held_addr || o_dump_data !== held_data) begin
                errors++;
                $display("FAIL dump_stable: got addr=%0d data=%h, required addr=%0d data=%h",
                         o_dump_addr, o_dump_data, held_addr, held_data);
            end
        end
        stab_armed = o_dump_valid && !i_dump_ready && !i_reset;
        held_addr  = o_dump_addr;
        held_data  = o_dump_data;

        if (o_dump_valid && i_dump_ready) begin
            checks++;
            if (dump_q.size() == 0) begin
                errors++;
                $display("FAIL dump_extra: got addr=%0d data=%h, required no word", o_dump_addr, o_dump_data);
            end else begin
                mon_w = dump_q.pop_front();
                $display("dump word addr=%0d data=%h", o_dump_addr, o_dump_data);
                if (o_dump_addr !== mon_w.addr || o_dump_data !== mon_w.data) begin
                    errors++;
                    $display("FAIL dump_word: got addr=%0d data=%h, required addr=%0d data=%h",
                             o_dump_addr, o_dump_data, mon_w.addr, mon_w.data);
                end
            end
        end

        if (o_dump_done) begin
            done_seen++;
            checks++;
            if (dump_q.size() != 0) begin
                errors++;
                $display("FAIL done_early: got %0d words outstanding, required 0", dump_q.size());
            end
        end

        while (check_q.size() > 0) begin
            mon_c = check_q.pop_front();
            case (mon_c.kind)
                K_RS:      mon_act = o_rs_data;
                K_RT:      mon_act = o_rt_data;
                K_HALTED:  mon_act = {31'd0, o_halted};
                K_VALID:   mon_act = {31'd0, o_dump_valid};
                K_DONE:    mon_act = {31'd0, o_dump_done};
                K_DADDR:   mon_act = {27'd0, o_dump_addr};
                K_DONECNT: mon_act = done_seen;
                K_DUMPQ:   mon_act = dump_q.size();
                default:   mon_act = 32'd0;
            endcase
            checks++;
            if (mon_act !== mon_c.exp) begin
                errors++;
                $display("FAIL %s: got %h, required %h", mon_c.name, mon_act, mon_c.exp);
            end
        end
    end

    task automatic expect_val(input int kind, input logic [31:0] exp, input string name);
        check_q.push_back('{kind, exp, name});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit reached;

        i_reset = 1'b1; i_rs_addr = '0; i_rt_addr = '0;
        i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0;
        i_halt = 1'b0; i_dump_start = 1'b0; i_dump_ready = 1'b0;
        step(); step();

        // Reset state
        i_reset = 1'b0; i_rs_addr = 5'd0; i_rt_addr = 5'd31;
        expect_val(K_RS, 32'h0, "reset_rs0");
        expect_val(K_RT, 32'h0, "reset_rt31");
        expect_val(K_HALTED, 32'h0, "reset_halted");
        expect_val(K_VALID, 32'h0, "reset_valid");
        expect_val(K_DONE, 32'h0, "reset_done");
        expect_val(K_DADDR, 32'h0, "reset_daddr");
        step();

        // Plain write then read
        i_wr_en = 1'b1; i_wr_addr = 5'd5; i_wr_data = 32'hDEAD_BEEF; i_rs_addr = 5'd1;
        expect_val(K_RS, 32'h0, "rs_r1_during_wr");
        step();
        i_wr_en = 1'b0; i_rs_addr = 5'd5;
        expect_val(K_RS, 32'hDEAD_BEEF, "read_r5");
        step();

        // r0 is hardwired to zero
        i_wr_en = 1'b1; i_wr_addr = 5'd0; i_wr_data = 32'h0000_1234; i_rs_addr = 5'd0; i_rt_addr = 5'd0;
        expect_val(K_RS, 32'h0, "r0_same_cycle");
        step();
        i_wr_en = 1'b0;
        expect_val(K_RS, 32'h0, "r0_after_rs");
        expect_val(K_RT, 32'h0, "r0_after_rt");
        step();

        // Same-cycle read of the register being written
        i_wr_en = 1'b1; i_wr_addr = 5'd7; i_wr_data = 32'hA5A5_A5A5; i_rs_addr = 5'd7; i_rt_addr = 5'd7;
        expect_val(K_RS, BYP_R7, "bypass_rs7");
        expect_val(K_RT, BYP_R7, "bypass_rt7");
        step();
        i_wr_en = 1'b0;
        expect_val(K_RS, 32'hA5A5_A5A5, "r7_after");
        step();

        // Dump request ignored while running
        i_dump_start = 1'b1;
        step();
        i_dump_start = 1'b0;
        expect_val(K_VALID, 32'h0, "start_ignored_run");
        expect_val(K_HALTED, 32'h0, "still_running");
        step();

        // Halt together with a write: the write commits
        i_halt = 1'b1; i_wr_en = 1'b1; i_wr_addr = 5'd3; i_wr_data = 32'h77; i_rs_addr = 5'd3;
        expect_val(K_HALTED, 32'h0, "halted_same_cycle");
        step();
        i_halt = 1'b0; i_wr_en = 1'b0;
        expect_val(K_HALTED, 32'h1, "halted_after");
        expect_val(K_RS, 32'h77, "r3_halt_write");
        step();

        // Writes ignored once halted
        i_wr_en = 1'b1; i_wr_addr = 5'd3; i_wr_data = 32'h99;
        expect_val(K_RS, 32'h77, "halt_wr_same");
        step();
        i_wr_en = 1'b0;
        expect_val(K_RS, 32'h77, "halt_wr_ignored");
        expect_val(K_HALTED, 32'h1, "halt_sticky");
        step();

        // Reset leaves HALTED and clears the array
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        expect_val(K_HALTED, 32'h0, "reset2_halted");
        expect_val(K_RS, 32'h0, "reset2_r3");
        step();

        // Load rN = N*0x10 and halt
        for (int n = 1; n < 32; n++) begin
            i_wr_en = 1'b1; i_wr_addr = 5'(n); i_wr_data = 32'(n * 16);
            step();
        end
        i_wr_en = 1'b0;
        i_halt = 1'b1;
        step();
        i_halt = 1'b0;
        expect_val(K_HALTED, 32'h1, "load_halted");
        step();

        // Full dump: ready low for 3 cycles, then random ready
        for (int a = 0; a < 32; a++) dump_q.push_back('{5'(a), 32'(a * 16)});
        i_dump_start = 1'b1; i_dump_ready = 1'b0;
        step();
        i_dump_start = 1'b0;
        expect_val(K_VALID, 32'h1, "dump_valid_first");
        expect_val(K_DADDR, 32'h0, "dump_addr_first");
        step(); step(); step();
        reached = 1'b0;
        for (int c = 0; c < 600; c++) begin
            i_dump_ready = 1'($urandom_range(0, 1));
            step();
            if (o_dump_done) begin
                reached = 1'b1;
                break;
            end
        end
        if (!reached) expect_val(K_TIMEOUT, 32'h1, "dump_timeout");
        i_dump_ready = 1'b0;
        expect_val(K_DONE, 32'h1, "done_pulse");
        expect_val(K_VALID, 32'h0, "valid_in_done");
        step();
        expect_val(K_DONE, 32'h0, "done_one_cycle");
        expect_val(K_HALTED, 32'h1, "back_to_halted");
        expect_val(K_VALID, 32'h0, "valid_after_done");
        step();

        // Restart the dump and abort it with reset at addr 12
        for (int a = 0; a < 12; a++) dump_q.push_back('{5'(a), 32'(a * 16)});
        i_dump_start = 1'b1;
        step();
        i_dump_start = 1'b0; i_dump_ready = 1'b1;
        reached = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (o_dump_valid && o_dump_addr == 5'd12) begin
                reached = 1'b1;
                break;
            end
            step();
        end
        if (!reached) expect_val(K_TIMEOUT, 32'h1, "addr12_timeout");
        i_dump_ready = 1'b0; i_reset = 1'b1;
        step();
        i_reset = 1'b0; i_rs_addr = 5'd5; i_rt_addr = 5'd31;
        expect_val(K_VALID, 32'h0, "abort_valid");
        expect_val(K_HALTED, 32'h0, "abort_halted");
        expect_val(K_DONE, 32'h0, "abort_no_done");
        expect_val(K_RS, 32'h0, "abort_r5");
        expect_val(K_RT, 32'h0, "abort_r31");
        step();
        expect_val(K_DONE, 32'h0, "abort_no_done_later");
        step();

        expect_val(K_DONECNT, 32'd1, "done_pulse_count");
        expect_val(K_DUMPQ, 32'd0, "dump_words_left");
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
